// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing defaults, coordinate width and window helper.
package vga_timing_pkg;

  localparam int COORD_W = 10;
  localparam int DIV_W   = 4;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int HSYNC_START = DEF_H_DISPLAY + DEF_H_FRONT;
  localparam int HSYNC_END   = HSYNC_START + DEF_H_SYNC;
  localparam int VSYNC_START = DEF_V_DISPLAY + DEF_V_FRONT;
  localparam int VSYNC_END   = VSYNC_START + DEF_V_SYNC;

  // Half-open window test lo <= v < hi, all unsigned coordinates.
  function automatic logic in_window(input logic [COORD_W-1:0] v,
                                     input logic [COORD_W-1:0] lo,
                                     input logic [COORD_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_pixel_div.sv
// Mod-CLK_DIV clock divider producing a one-clk pixel_tick strobe.
module vga_pixel_div
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic pixel_tick
);

  localparam logic [DIV_W-1:0] D_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] d;

  // Free-running divide counter; strobe registered from the terminal count.
  always_ff @(posedge clk) begin
    if (reset) begin
      d          <= '0;
      pixel_tick <= 1'b0;
    end else begin
      d          <= (d == D_LAST) ? '0 : d + 1'b1;
      pixel_tick <= (d == D_LAST);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing master: raster counters, registered sync/video_on aligned with
// the coordinates. Define VGA_SYNC_FRAME_TICK_EN to add the frame_tick port.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pixel_tick,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync
`ifdef VGA_SYNC_FRAME_TICK_EN
  ,
  output logic               frame_tick
`endif
);

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_DISPLAY);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_DISPLAY);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_DISPLAY + H_FRONT);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_DISPLAY + V_FRONT);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [COORD_W-1:0] x_next;
  logic [COORD_W-1:0] y_next;

  vga_pixel_div #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .pixel_tick(pixel_tick)
  );

  // Next raster position: step only in a cycle where pixel_tick is high.
  always_comb begin
    x_next = pixel_x;
    y_next = pixel_y;
    if (pixel_tick) begin
      if (pixel_x == H_LAST) begin
        x_next = '0;
        y_next = (pixel_y == V_LAST) ? '0 : pixel_y + 1'b1;
      end else begin
        x_next = pixel_x + 1'b1;
      end
    end
  end

  // Coordinates and decoded timing share one edge, so they never skew.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_x  <= '0;
      pixel_y  <= '0;
      video_on <= 1'b0;
      hsync    <= ~SYNC_POL;
      vsync    <= ~SYNC_POL;
    end else begin
      pixel_x  <= x_next;
      pixel_y  <= y_next;
      video_on <= (x_next < H_VIS) && (y_next < V_VIS);
      hsync    <= in_window(x_next, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
      vsync    <= in_window(y_next, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
    end
  end

`ifdef VGA_SYNC_FRAME_TICK_EN
  logic frame_wrap;
  assign frame_wrap = pixel_tick && (pixel_x == H_LAST) && (pixel_y == V_LAST);

  // One-clk strobe on the edge where the raster returns to (0,0).
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_wrap;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size timing (CLK_DIV=4, active-low sync) and a
// shrunken raster (CLK_DIV=1, active-high sync) against an arithmetic model.
module tb_vga_sync_gen;

  typedef struct packed {
    logic       tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       hs;
    logic       vs;
    logic       ft;
  } out_t;

  logic clk = 1'b0;
  logic ra, rb;
  logic pta, ptb, vona, vonb, hsa, hsb, vsa, vsb, fta, ftb;
  logic [9:0] xa, ya, xb, yb;

  int n_pass = 0;
  int n_total = 0;
  int ka = 0, kb = 0, cyc = 0;
  out_t act_a, exp_a, act_b, exp_b;

  always #5 clk = ~clk;

  vga_sync_gen dut_a (
    .clk(clk), .reset(ra), .pixel_tick(pta), .pixel_x(xa), .pixel_y(ya),
    .video_on(vona), .hsync(hsa), .vsync(vsa)
`ifdef VGA_SYNC_FRAME_TICK_EN
    , .frame_tick(fta)
`endif
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
    .V_DISPLAY(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), .reset(rb), .pixel_tick(ptb), .pixel_x(xb), .pixel_y(yb),
    .video_on(vonb), .hsync(hsb), .vsync(vsb)
`ifdef VGA_SYNC_FRAME_TICK_EN
    , .frame_tick(ftb)
`endif
  );

`ifndef VGA_SYNC_FRAME_TICK_EN
  assign fta = 1'b0;
  assign ftb = 1'b0;
`endif

  // Outputs after k non-reset edges since the last reset edge (k=0: in reset).
  function automatic out_t model(int k, int d, int hd, int hf, int hs, int hb,
                                 int vd, int vf, int vs, int vb, bit pol);
    out_t o;
    int ht, vt, p, pos, x, y;
    bit adv;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    if (k == 0) begin
      o.tick = 1'b0; o.x = '0; o.y = '0; o.von = 1'b0;
      o.hs = ~pol; o.vs = ~pol; o.ft = 1'b0;
      return o;
    end
    p   = (k - 1) / d;
    pos = p % (ht * vt);
    x   = pos % ht;
    y   = pos / ht;
    adv = (k - 1 >= 1) && ((k - 1) % d == 0);
    o.tick = (k % d == 0);
    o.x    = 10'(x);
    o.y    = 10'(y);
    o.von  = (x < hd) && (y < vd);
    o.hs   = (x >= hd + hf && x < hd + hf + hs) ? pol : ~pol;
    o.vs   = (y >= vd + vf && y < vd + vf + vs) ? pol : ~pol;
`ifdef VGA_SYNC_FRAME_TICK_EN
    o.ft   = adv && (pos == 0);
`else
    o.ft   = 1'b0;
`endif
    return o;
  endfunction

  // Advance one clock, track model time per DUT, capture actual and expected.
  task automatic clk_step();
    @(posedge clk);
    ka = ra ? 0 : ka + 1;
    kb = rb ? 0 : kb + 1;
    cyc++;
    #1;
    act_a = {pta, xa, ya, vona, hsa, vsa, fta};
    act_b = {ptb, xb, yb, vonb, hsb, vsb, ftb};
    exp_a = model(ka, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
    exp_b = model(kb, 1, 16, 4, 6, 4, 10, 2, 2, 3, 1'b1);
  endtask

  task automatic test_reset();
    ra = 1'b1; rb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      clk_step();
      n_total++;
      if (act_a !== exp_a) $display("FAIL reset_a act=%h exp=%h", act_a, exp_a); else n_pass++;
      n_total++;
      if (act_b !== exp_b) $display("FAIL reset_b act=%h exp=%h", act_b, exp_b); else n_pass++;
    end
    n_total++;
    if ({pta, xa, ya, vona, hsa, vsa} !== {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1})
      $display("FAIL reset_vals_a act=%b_%0d_%0d_%b%b%b exp=0_0_0_011", pta, xa, ya, vona, hsa, vsa);
    else n_pass++;
  endtask

  task automatic test_first_pixels();
    ra = 1'b0; rb = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      clk_step();
      n_total++;
      if (act_a !== exp_a) $display("FAIL first_a i=%0d act=%h exp=%h", i, act_a, exp_a); else n_pass++;
      n_total++;
      if (act_b !== exp_b) $display("FAIL first_b i=%0d act=%h exp=%h", i, act_b, exp_b); else n_pass++;
      if (i == 1) begin
        n_total++;
        if (vona !== 1'b1 || xa !== 10'd0 || pta !== 1'b0)
          $display("FAIL first_clk_a von=%b x=%0d tick=%b exp von=1 x=0 tick=0", vona, xa, pta);
        else n_pass++;
        n_total++;
        if (ptb !== 1'b1) $display("FAIL first_tick_b act=%b exp=1", ptb); else n_pass++;
      end
      if (i == 4) begin
        n_total++;
        if (pta !== 1'b1) $display("FAIL tick4_a act=%b exp=1", pta); else n_pass++;
      end
      if (i == 5) begin
        n_total++;
        if (xa !== 10'd1) $display("FAIL x_after_tick_a act=%0d exp=1", xa); else n_pass++;
      end
    end
  endtask

  task automatic test_hsync_line();
    logic prev_hs, prev_y0;
    int fall_x = -1, rise_x = -1, low_cyc = 0, wrap_x = -1;
    logic wrap_von = 1'b0;
    prev_hs = hsa;
    prev_y0 = (ya == 10'd0);
    for (int i = 0; i < 3210; i++) begin
      clk_step();
      n_total++;
      if (act_a !== exp_a) $display("FAIL line_a k=%0d act=%h exp=%h", ka, act_a, exp_a); else n_pass++;
      n_total++;
      if (act_b !== exp_b) $display("FAIL line_b k=%0d act=%h exp=%h", kb, act_b, exp_b); else n_pass++;
      if (prev_hs && !hsa) fall_x = xa;
      if (!prev_hs && hsa && rise_x < 0) rise_x = xa;
      if (!hsa && rise_x < 0) low_cyc++;
      if (prev_y0 && ya == 10'd1) begin wrap_x = xa; wrap_von = vona; end
      prev_hs = hsa;
      prev_y0 = (ya == 10'd0);
    end
    n_total++;
    if (fall_x != 656) $display("FAIL hsync_fall_x act=%0d exp=656", fall_x); else n_pass++;
    n_total++;
    if (rise_x != 752) $display("FAIL hsync_rise_x act=%0d exp=752", rise_x); else n_pass++;
    n_total++;
    if (low_cyc != 96 * 4) $display("FAIL hsync_width_clks act=%0d exp=384", low_cyc); else n_pass++;
    n_total++;
    if (wrap_x != 0 || wrap_von !== 1'b1)
      $display("FAIL line_wrap x=%0d von=%b exp x=0 von=1", wrap_x, wrap_von);
    else n_pass++;
  endtask

  task automatic test_frame();
    logic prev_vs;
    int run = -1, runs = 0, last_ft = -1, n_ft = 0;
    prev_vs = vsb;
    for (int i = 0; i < 1200; i++) begin
      clk_step();
      n_total++;
      if (act_a !== exp_a) $display("FAIL frame_a k=%0d act=%h exp=%h", ka, act_a, exp_a); else n_pass++;
      n_total++;
      if (act_b !== exp_b) $display("FAIL frame_b k=%0d act=%h exp=%h", kb, act_b, exp_b); else n_pass++;
      if (!prev_vs && vsb) run = 0;
      if (vsb && run >= 0) run++;
      if (prev_vs && !vsb && run >= 0) begin
        runs++;
        n_total++;
        if (run != 2 * 30) $display("FAIL vsync_width_b act=%0d exp=60", run); else n_pass++;
        run = -1;
      end
      prev_vs = vsb;
`ifdef VGA_SYNC_FRAME_TICK_EN
      if (ftb) begin
        n_total++;
        if (xb !== 10'd0 || yb !== 10'd0)
          $display("FAIL frame_tick_pos_b x=%0d y=%0d exp 0,0", xb, yb);
        else n_pass++;
        if (last_ft >= 0) begin
          n_total++;
          if (cyc - last_ft != 510) $display("FAIL frame_period_b act=%0d exp=510", cyc - last_ft); else n_pass++;
        end
        last_ft = cyc;
        n_ft++;
      end
`endif
    end
    n_total++;
    if (runs < 2) $display("FAIL vsync_runs_b act=%0d exp>=2", runs); else n_pass++;
`ifdef VGA_SYNC_FRAME_TICK_EN
    n_total++;
    if (n_ft < 2) $display("FAIL frame_tick_count_b act=%0d exp>=2", n_ft); else n_pass++;
`endif
  endtask

  task automatic test_mid_reset();
    for (int it = 0; it < 6; it++) begin
      int n, h;
      n = $urandom_range(5, 700);
      h = $urandom_range(1, 3);
      ra = 1'b0; rb = 1'b0;
      for (int i = 0; i < n; i++) begin
        clk_step();
        n_total++;
        if (act_a !== exp_a) $display("FAIL run_a k=%0d act=%h exp=%h", ka, act_a, exp_a); else n_pass++;
        n_total++;
        if (act_b !== exp_b) $display("FAIL run_b k=%0d act=%h exp=%h", kb, act_b, exp_b); else n_pass++;
      end
      ra = 1'b1; rb = 1'b1;
      for (int i = 0; i < h; i++) begin
        clk_step();
        n_total++;
        if ({pta, xa, ya, vona, hsa, vsa} !== {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1})
          $display("FAIL midreset_a act=%b_%0d_%0d_%b%b%b exp=0_0_0_011", pta, xa, ya, vona, hsa, vsa);
        else n_pass++;
        n_total++;
        if (act_b !== exp_b) $display("FAIL midreset_b act=%h exp=%h", act_b, exp_b); else n_pass++;
      end
    end
    ra = 1'b0; rb = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 1500; i++) begin
      ra = ($urandom_range(0, 99) == 0);
      rb = ($urandom_range(0, 39) == 0);
      clk_step();
      n_total++;
      if (act_a !== exp_a) $display("FAIL b2b_a k=%0d act=%h exp=%h", ka, act_a, exp_a); else n_pass++;
      n_total++;
      if (act_b !== exp_b) $display("FAIL b2b_b k=%0d act=%h exp=%h", kb, act_b, exp_b); else n_pass++;
    end
    ra = 1'b0; rb = 1'b0;
  endtask

  initial begin
    ra = 1'b1; rb = 1'b1;
    test_reset();
    test_first_pixels();
    test_hsync_line();
    test_frame();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
